// File: rtl/rx_share_pkg.sv
// Shared types and constants for the receiver-sharing arbiter.
// Watchdog constants are used only when RX_SHARE_ARB_TIMEOUT_EN is defined.
package rx_share_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_MAX = 15;
  localparam int WDOG_W      = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request found searching upward
// from i_rr_ptr, with wrap. i_rr_ptr must lie in 0..N_REQ-1.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    w_sum [N_REQ];
  logic [IDX_W-1:0] w_pos [N_REQ];

  // w_pos[k] is the requester k places after the pointer; sum stays below 2*N_REQ
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pos
      assign w_sum[gi] = {1'b0, i_rr_ptr} + SW'(gi);
      assign w_pos[gi] = (w_sum[gi] >= SW'(N_REQ)) ? IDX_W'(w_sum[gi] - SW'(N_REQ))
                                                    : IDX_W'(w_sum[gi]);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (i_req[w_pos[off]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[off];
      end
    end
  end

endmodule

// File: rtl/rx_share_arbiter.sv
// Round-robin share of one four-phase receiver channel among N_REQ senders.
// Define RX_SHARE_ARB_TIMEOUT_EN to add a SEND watchdog and TimeoutErr output.
module rx_share_arbiter
  import rx_share_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        ReqIn,
  input  logic [N_REQ*DATA_W-1:0] DataBus,
  output logic [N_REQ-1:0]        AckOut,
  output logic                    RxRequest,
  output logic [DATA_W-1:0]       RxData,
  input  logic                    RxAck,
  output logic [IDX_W-1:0]        GrantIdx,
  output logic                    Busy
`ifdef RX_SHARE_ARB_TIMEOUT_EN
  ,
  output logic                    TimeoutErr
`endif
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_rx_req;
  logic [N_REQ-1:0]   r_ack_out;
`ifdef RX_SHARE_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0]  r_wdog;
  logic               r_timeout;
`endif

  logic [DATA_W-1:0]  w_slice [N_REQ];
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_next_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slice[gi] = DataBus[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (ReqIn),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  assign w_next_ptr = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_rx_data <= '0;
      r_rx_req  <= 1'b0;
      r_ack_out <= '0;
`ifdef RX_SHARE_ARB_TIMEOUT_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_ack_out <= '0;
`ifdef RX_SHARE_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant   <= w_pick_idx;
            r_rx_data <= w_slice[w_pick_idx];
            r_rx_req  <= 1'b1;
            r_state   <= SEND;
`ifdef RX_SHARE_ARB_TIMEOUT_EN
            r_wdog    <= '0;
`endif
          end
        end
        SEND: begin
          if (RxAck) begin
            r_rx_req  <= 1'b0;
            r_ack_out <= N_REQ'(1) << r_grant;
            r_state   <= ACK;
          end
`ifdef RX_SHARE_ARB_TIMEOUT_EN
          // Give up on the 15th SEND cycle without an ack; no AckOut is issued.
          else if (r_wdog == WDOG_W'(TIMEOUT_MAX - 1)) begin
            r_rx_req  <= 1'b0;
            r_timeout <= 1'b1;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= RELEASE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        ACK: begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= RELEASE;
        end
        RELEASE: begin
          // Both sides must finish the return-to-zero phase before a new grant.
          if (!ReqIn[r_grant] && !RxAck) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign AckOut     = r_ack_out;
  assign RxRequest  = r_rx_req;
  assign RxData     = r_rx_data;
  assign GrantIdx   = r_grant;
  assign Busy       = (r_state != IDLE);
`ifdef RX_SHARE_ARB_TIMEOUT_EN
  assign TimeoutErr = r_timeout;
`endif

endmodule

// File: tb/tb_rx_share_arbiter.sv
// Directed scoreboard bench for rx_share_arbiter; expected grants are queued
// when requests are driven and popped when the receiver sees RxRequest.
module tb_rx_share_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 2;

  logic                    clk = 1'b0;
  logic                    Reset;
  logic [N_REQ-1:0]        ReqIn;
  logic [N_REQ*DATA_W-1:0] DataBus;
  logic [N_REQ-1:0]        AckOut;
  logic                    RxRequest;
  logic [DATA_W-1:0]       RxData;
  logic                    RxAck;
  logic [IDX_W-1:0]        GrantIdx;
  logic                    Busy;
  logic                    TimeoutErr;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rx_share_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .ReqIn     (ReqIn),
    .DataBus   (DataBus),
    .AckOut    (AckOut),
    .RxRequest (RxRequest),
    .RxData    (RxData),
    .RxAck     (RxAck),
    .GrantIdx  (GrantIdx),
    .Busy      (Busy)
`ifdef RX_SHARE_ARB_TIMEOUT_EN
    ,
    .TimeoutErr(TimeoutErr)
`endif
  );

`ifndef RX_SHARE_ARB_TIMEOUT_EN
  assign TimeoutErr = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(input int i, input logic [DATA_W-1:0] v);
    DataBus[i*DATA_W +: DATA_W] = v;
  endtask

  // Receiver model: wait for a request, check it against the scoreboard,
  // ack one cycle later, then complete the return-to-zero handshake.
  task automatic serve(input bit rearm);
    exp_t e;
    int   waited;
    int   idx;
    waited = 0;
    while (!RxRequest && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(RxRequest), 32'd1);
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    e   = sb.pop_front();
    idx = int'(e.idx);
    check("grant_idx", 32'(GrantIdx), 32'(e.idx));
    check("rx_data", 32'(RxData), 32'(e.data));
    check("busy_send", 32'(Busy), 32'd1);
    $display("[TB] transfer grant=%0d data=%h expected_grant=%0d expected_data=%h",
             GrantIdx, RxData, e.idx, e.data);
    RxAck = 1'b1;
    @(negedge clk);
    check("ack_onehot", 32'(AckOut), 32'd1 << idx);
    check("rxreq_low_ack", 32'(RxRequest), 32'd0);
    ReqIn[idx] = 1'b0;
    RxAck      = 1'b0;
    @(negedge clk);
    check("ack_pulse_end", 32'(AckOut), 32'd0);
    check("busy_release", 32'(Busy), 32'd1);
    @(negedge clk);
    check("busy_idle", 32'(Busy), 32'd0);
    if (rearm) ReqIn[idx] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    Reset   = 1'b1;
    ReqIn   = '0;
    RxAck   = 1'b0;
    DataBus = '0;
    set_slice(0, 16'hA000);
    set_slice(1, 16'hB111);
    set_slice(2, 16'hBEEF);
    set_slice(3, 16'hD003);
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ackout", 32'(AckOut), 32'd0);
    check("rst_rxreq", 32'(RxRequest), 32'd0);
    check("rst_rxdata", 32'(RxData), 32'd0);
    check("rst_grant", 32'(GrantIdx), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);

    // All four requesting continuously: order 0,1,2,3,0
    sb.push_back('{idx: 2'd0, data: 16'hA000});
    sb.push_back('{idx: 2'd1, data: 16'hB111});
    sb.push_back('{idx: 2'd2, data: 16'hBEEF});
    sb.push_back('{idx: 2'd3, data: 16'hD003});
    sb.push_back('{idx: 2'd0, data: 16'hA000});
    ReqIn = 4'b1111;
    for (int k = 0; k < 4; k++) serve(1'b1);
    serve(1'b0);
    ReqIn = 4'b0000;
    repeat (2) @(negedge clk);
    check("idle_no_req", 32'(RxRequest), 32'd0);

    // Single request from sender 2, one-cycle grant latency (rr_ptr = 1)
    sb.push_back('{idx: 2'd2, data: 16'hBEEF});
    ReqIn = 4'b0100;
    @(negedge clk);
    check("latency_rxreq", 32'(RxRequest), 32'd1);
    serve(1'b0);

    // Sender 1 changes data during SEND; release waits for ReqIn[1]=0 and RxAck=0
    set_slice(1, 16'h1111);
    ReqIn = 4'b0010;
    @(negedge clk);
    check("hold_grant", 32'(GrantIdx), 32'd1);
    check("hold_data0", 32'(RxData), 32'h1111);
    set_slice(1, 16'h2222);
    ReqIn[3] = 1'b1;
    repeat (2) @(negedge clk);
    check("hold_data1", 32'(RxData), 32'h1111);
    check("hold_grant1", 32'(GrantIdx), 32'd1);
    $display("[TB] transfer grant=%0d data=%h (data changed during SEND)", GrantIdx, RxData);
    RxAck = 1'b1;
    @(negedge clk);
    check("hold_ack", 32'(AckOut), 32'b0010);
    RxAck = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_req_busy", 32'(Busy), 32'd1);
    check("rel_req_rxreq", 32'(RxRequest), 32'd0);
    check("rel_req_ack", 32'(AckOut), 32'd0);
    ReqIn[1] = 1'b0;
    RxAck    = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_ack_busy", 32'(Busy), 32'd1);
    RxAck = 1'b0;
    @(negedge clk);
    check("rel_done_busy", 32'(Busy), 32'd0);

    // Grant 3, then ReqIn=1001 wraps to 0 before 3 again (rr_ptr = 2)
    sb.push_back('{idx: 2'd3, data: 16'hD003});
    serve(1'b1);
    ReqIn[0] = 1'b1;
    sb.push_back('{idx: 2'd0, data: 16'hA000});
    serve(1'b0);
    sb.push_back('{idx: 2'd3, data: 16'hD003});
    serve(1'b0);
    ReqIn = 4'b0000;
    @(negedge clk);

`ifdef RX_SHARE_ARB_TIMEOUT_EN
    // Watchdog: no RxAck; TimeoutErr pulses 15 cycles after RxRequest rises
    ReqIn = 4'b0011;
    @(negedge clk);
    check("to_rxreq", 32'(RxRequest), 32'd1);
    check("to_grant", 32'(GrantIdx), 32'd0);
    repeat (14) @(negedge clk);
    check("to_early", 32'(TimeoutErr), 32'd0);
    check("to_early_req", 32'(RxRequest), 32'd1);
    @(negedge clk);
    check("to_pulse", 32'(TimeoutErr), 32'd1);
    check("to_req_drop", 32'(RxRequest), 32'd0);
    check("to_no_ack", 32'(AckOut), 32'd0);
    $display("[TB] transfer grant=%0d timed out", GrantIdx);
    ReqIn[0] = 1'b0;
    @(negedge clk);
    check("to_pulse_end", 32'(TimeoutErr), 32'd0);
    sb.push_back('{idx: 2'd1, data: 16'h2222});
    serve(1'b0);
    ReqIn = 4'b0000;
    @(negedge clk);
`endif

    // Move rr_ptr off zero so its reset value is observable afterwards
    sb.push_back('{idx: 2'd1, data: 16'h2222});
    ReqIn = 4'b0010;
    serve(1'b0);

    // Asynchronous reset mid-SEND
    set_slice(0, 16'hC0DE);
    ReqIn = 4'b0001;
    @(negedge clk);
    check("mid_rxreq", 32'(RxRequest), 32'd1);
    check("mid_rxdata", 32'(RxData), 32'hC0DE);
    #2 Reset = 1'b1;
    #1;
    check("arst_rxreq", 32'(RxRequest), 32'd0);
    check("arst_ackout", 32'(AckOut), 32'd0);
    check("arst_grant", 32'(GrantIdx), 32'd0);
    check("arst_rxdata", 32'(RxData), 32'd0);
    check("arst_busy", 32'(Busy), 32'd0);
    $display("[TB] transfer dropped by reset");
    ReqIn = 4'b0000;
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("post_rst_ack", 32'(AckOut), 32'd0);
    check("post_rst_busy", 32'(Busy), 32'd0);

    // rr_ptr must be back at 0: all requesting -> grant 0
    sb.push_back('{idx: 2'd0, data: 16'hC0DE});
    ReqIn = 4'b1111;
    serve(1'b0);
    ReqIn = 4'b0000;
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
